riscv_rf_wb_arbiter: RTL and testbench

Writeback arbiter and pending-write scoreboard for the RI5CY flip-flop register file. It accepts writeback requests from up to NUM_REQ execution units (ALU, MULT, LSU, DIV) over valid/ready handshakes and schedules at most two per cycle onto the register file's two write ports. Same-address collisions within a cycle are never issued. An optional scoreboard tracks destinations with outstanding writes so the decode stage can stall on read-after-write hazards.

---
 rtl/riscv_rf_wb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_riscv_rf_wb_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_rf_wb_arbiter.sv
// ============================================================================
// Module   : riscv_rf_wb_arbiter
// Brief    : Round-robin writeback arbiter feeding the two register-file write
//            ports, plus an optional pending-write scoreboard for RAW stalls.
//            The scoreboard is built only when RF_WB_SCOREBOARD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    output logic [ADDR_WIDTH-1:0]                waddr_a_o,
    output logic [DATA_WIDTH-1:0]                wdata_a_o,
    output logic                                 we_a_o,
    output logic [ADDR_WIDTH-1:0]                waddr_b_o,
    output logic [DATA_WIDTH-1:0]                wdata_b_o,
    output logic                                 we_b_o,
    input  logic                                 alloc_valid_i,
    input  logic [ADDR_WIDTH-1:0]                alloc_addr_i,
    input  logic                                 flush_i,
    output logic [2**ADDR_WIDTH-1:0]             busy_o
);

    localparam int c_ptr_w    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_num_regs = 2**ADDR_WIDTH;

    logic [c_ptr_w-1:0]     r_ptr;
    logic [c_ptr_w-1:0]     w_ptr_nxt;
    logic [c_ptr_w-1:0]     w_scan;
    logic [c_ptr_w-1:0]     w_idx_a;
    logic [c_ptr_w-1:0]     w_idx_b;
    logic                   w_gnt_a;
    logic                   w_gnt_b;
    logic [NUM_REQ-1:0]     w_ready;

    logic [ADDR_WIDTH-1:0]  r_waddr_a;
    logic [DATA_WIDTH-1:0]  r_wdata_a;
    logic                   r_we_a;
    logic [ADDR_WIDTH-1:0]  r_waddr_b;
    logic [DATA_WIDTH-1:0]  r_wdata_b;
    logic                   r_we_b;

    // Scan requesters from the pointer: first valid wins A, next valid with a different address wins B.
    always_comb begin
        w_ready = '0;
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        w_idx_a = '0;
        w_idx_b = '0;
        w_scan  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = c_ptr_w'((int'(r_ptr) + i) % NUM_REQ);
            if (req_valid_i[w_scan]) begin
                if (!w_gnt_a) begin
                    w_gnt_a         = 1'b1;
                    w_idx_a         = w_scan;
                    w_ready[w_scan] = 1'b1;
                end else if (!w_gnt_b && (req_addr_i[w_scan] != req_addr_i[w_idx_a])) begin
                    w_gnt_b         = 1'b1;
                    w_idx_b         = w_scan;
                    w_ready[w_scan] = 1'b1;
                end
            end
        end
    end

    // Pointer moves just past the last granted requester; holds when idle.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_gnt_b) begin
            w_ptr_nxt = c_ptr_w'((int'(w_idx_b) + 1) % NUM_REQ);
        end else if (w_gnt_a) begin
            w_ptr_nxt = c_ptr_w'((int'(w_idx_a) + 1) % NUM_REQ);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Register the granted writes; x0 grants use the slot but never enable the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr_a <= '0;
            r_wdata_a <= '0;
            r_we_a    <= 1'b0;
            r_waddr_b <= '0;
            r_wdata_b <= '0;
            r_we_b    <= 1'b0;
        end else begin
            if (w_gnt_a) begin
                r_waddr_a <= req_addr_i[w_idx_a];
                r_wdata_a <= req_data_i[w_idx_a];
                r_we_a    <= |req_addr_i[w_idx_a];
            end else begin
                r_we_a    <= 1'b0;
            end
            if (w_gnt_b) begin
                r_waddr_b <= req_addr_i[w_idx_b];
                r_wdata_b <= req_data_i[w_idx_b];
                r_we_b    <= |req_addr_i[w_idx_b];
            end else begin
                r_we_b    <= 1'b0;
            end
        end
    end

    assign req_ready_o = w_ready;
    assign waddr_a_o   = r_waddr_a;
    assign wdata_a_o   = r_wdata_a;
    assign we_a_o      = r_we_a;
    assign waddr_b_o   = r_waddr_b;
    assign wdata_b_o   = r_wdata_b;
    assign we_b_o      = r_we_b;

`ifdef RF_WB_SCOREBOARD_EN
    logic [c_num_regs-1:0] r_busy;
    logic [c_num_regs-1:0] w_busy_nxt;

    // Clear on the write leaving the port, then set on allocation (set wins), flush overrides all.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we_a) begin
            w_busy_nxt[r_waddr_a] = 1'b0;
        end
        if (r_we_b) begin
            w_busy_nxt[r_waddr_b] = 1'b0;
        end
        if (alloc_valid_i && (alloc_addr_i != '0)) begin
            w_busy_nxt[alloc_addr_i] = 1'b1;
        end
        if (flush_i) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Pending-write flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_o = r_busy;
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{alloc_valid_i, alloc_addr_i, flush_i};
    assign busy_o      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_rf_wb_arbiter.sv
// ============================================================================
// Module   : tb_riscv_rf_wb_arbiter
// Brief    : Self-checking bench for riscv_rf_wb_arbiter: directed scenarios
//            plus randomized traffic against a queue-based reference model.
//            Scoreboard checks follow RF_WB_SCOREBOARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_rf_wb_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NR   = 4;
    localparam int NREG = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0][AW-1:0] req_addr;
    logic [NR-1:0][DW-1:0] req_data;
    logic [NR-1:0]        req_ready;
    logic [AW-1:0]        waddr_a, waddr_b;
    logic [DW-1:0]        wdata_a, wdata_b;
    logic                 we_a, we_b;
    logic                 alloc_valid;
    logic [AW-1:0]        alloc_addr;
    logic                 flush;
    logic [NREG-1:0]      busy;

    always #5 clk = ~clk;

    riscv_rf_wb_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_addr_i    (req_addr),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .waddr_a_o     (waddr_a),
        .wdata_a_o     (wdata_a),
        .we_a_o        (we_a),
        .waddr_b_o     (waddr_b),
        .wdata_b_o     (wdata_b),
        .we_b_o        (we_b),
        .alloc_valid_i (alloc_valid),
        .alloc_addr_i  (alloc_addr),
        .flush_i       (flush),
        .busy_o        (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int              m_ptr;
    logic [NR-1:0]   m_ready;
    logic            m_ga, m_gb;
    int              m_ia, m_ib;
    logic            m_we_a, m_we_b;
    logic [AW-1:0]   m_waddr_a, m_waddr_b;
    logic [DW-1:0]   m_wdata_a, m_wdata_b;
    logic [NREG-1:0] m_busy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_ready   = '0;
        m_ga      = 1'b0;
        m_gb      = 1'b0;
        m_ia      = 0;
        m_ib      = 0;
        m_we_a    = 1'b0;
        m_we_b    = 1'b0;
        m_waddr_a = '0;
        m_waddr_b = '0;
        m_wdata_a = '0;
        m_wdata_b = '0;
        m_busy    = '0;
    endtask

    // Build the list of valid requesters in scan order, then pick A and B from it.
    task automatic model_arb();
        int order[$];
        m_ready = '0;
        m_ga = 1'b0;
        m_gb = 1'b0;
        m_ia = 0;
        m_ib = 0;
        for (int k = 0; k < NR; k++)
            if (req_valid[(m_ptr + k) % NR]) order.push_back((m_ptr + k) % NR);
        if (order.size() > 0) begin
            m_ga = 1'b1;
            m_ia = order[0];
            m_ready[m_ia] = 1'b1;
            for (int j = 1; j < order.size(); j++) begin
                if (!m_gb && (req_addr[order[j]] != req_addr[m_ia])) begin
                    m_gb = 1'b1;
                    m_ib = order[j];
                    m_ready[m_ib] = 1'b1;
                end
            end
        end
    endtask

    // Inputs are driven; settle and compare the combinational ready vector.
    task automatic eval();
        #1;
        model_arb();
        check("ready", 64'(req_ready), 64'(m_ready));
    endtask

    // Cross the clock edge, update the model, compare all registered outputs.
    task automatic advance();
        logic [NREG-1:0] nb;
        nb = m_busy;
`ifdef RF_WB_SCOREBOARD_EN
        if (m_we_a) nb[m_waddr_a] = 1'b0;
        if (m_we_b) nb[m_waddr_b] = 1'b0;
        if (alloc_valid && (alloc_addr != 0)) nb[alloc_addr] = 1'b1;
        if (flush) nb = '0;
`endif
        @(posedge clk);
        #1;
        m_busy = nb;
        if (m_ga) begin
            m_waddr_a = req_addr[m_ia];
            m_wdata_a = req_data[m_ia];
            m_we_a    = (req_addr[m_ia] != 0);
        end else begin
            m_we_a    = 1'b0;
        end
        if (m_gb) begin
            m_waddr_b = req_addr[m_ib];
            m_wdata_b = req_data[m_ib];
            m_we_b    = (req_addr[m_ib] != 0);
        end else begin
            m_we_b    = 1'b0;
        end
        if (m_gb) m_ptr = (m_ib + 1) % NR;
        else if (m_ga) m_ptr = (m_ia + 1) % NR;
        check("we_a",    64'(we_a),    64'(m_we_a));
        check("waddr_a", 64'(waddr_a), 64'(m_waddr_a));
        check("wdata_a", 64'(wdata_a), 64'(m_wdata_a));
        check("we_b",    64'(we_b),    64'(m_we_b));
        check("waddr_b", 64'(waddr_b), 64'(m_waddr_b));
        check("wdata_b", 64'(wdata_b), 64'(m_wdata_b));
        check("busy",    64'(busy),    64'(m_busy));
    endtask

    task automatic set_req(input int k, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[k] = v;
        req_addr[k]  = a;
        req_data[k]  = d;
    endtask

    task automatic clr_reqs();
        req_valid = '0;
    endtask

    initial begin
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
        flush       = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_we_a",  64'(we_a),      64'(0));
        check("rst_we_b",  64'(we_b),      64'(0));
        check("rst_waddr_a", 64'(waddr_a), 64'(0));
        check("rst_wdata_b", 64'(wdata_b), 64'(0));
        check("rst_busy",  64'(busy),      64'(0));
        rst_n = 1'b1;

        // Requester 1 alone writes x5
        clr_reqs();
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        eval();
        check("t1_ready", 64'(req_ready), 64'(4'b0010));
        advance();
        check("t1_we_a",    64'(we_a),    64'(1));
        check("t1_waddr_a", 64'(waddr_a), 64'(5));
        check("t1_wdata_a", 64'(wdata_a), 64'(32'hDEADBEEF));
        check("t1_we_b",    64'(we_b),    64'(0));

        // Bring the pointer back to 0 via requester 3
        clr_reqs();
        set_req(3, 1'b1, 5'd11, 32'h33);
        eval();
        advance();
        check("t2_model_ptr0", 64'(m_ptr), 64'(0));

        // Four requesters, addresses 1..4
        clr_reqs();
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, AW'(k + 1), DW'(32'h100 + k));
        eval();
        check("t2_ready01", 64'(req_ready), 64'(4'b0011));
        advance();
        check("t2_waddr_a1", 64'(waddr_a), 64'(1));
        check("t2_waddr_b2", 64'(waddr_b), 64'(2));
        check("t2_we_b",     64'(we_b),    64'(1));
        check("t2_model_ptr2", 64'(m_ptr), 64'(2));
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        eval();
        check("t2_ready23", 64'(req_ready), 64'(4'b1100));
        advance();
        check("t2_waddr_a3", 64'(waddr_a), 64'(3));
        check("t2_waddr_b4", 64'(waddr_b), 64'(4));
        check("t2_model_ptr0b", 64'(m_ptr), 64'(0));

        // Same-address collision: 0 and 1 -> x7, 2 -> x8
        clr_reqs();
        set_req(0, 1'b1, 5'd7, 32'hA0);
        set_req(1, 1'b1, 5'd7, 32'hA1);
        set_req(2, 1'b1, 5'd8, 32'hA2);
        eval();
        check("t3_ready", 64'(req_ready), 64'(4'b0101));
        advance();
        check("t3_waddr_a", 64'(waddr_a), 64'(7));
        check("t3_wdata_a", 64'(wdata_a), 64'(32'hA0));
        check("t3_waddr_b", 64'(waddr_b), 64'(8));
        check("t3_model_ptr3", 64'(m_ptr), 64'(3));
        req_valid[0] = 1'b0;
        req_valid[2] = 1'b0;
        eval();
        check("t3_ready1", 64'(req_ready), 64'(4'b0010));
        advance();
        check("t3_wdata_a1", 64'(wdata_a), 64'(32'hA1));
        check("t3_waddr_a1", 64'(waddr_a), 64'(7));

        // Write to x0 consumes the slot but never enables the write
        clr_reqs();
        set_req(0, 1'b1, 5'd0, 32'h1234);
        eval();
        check("t4_ready", 64'(req_ready), 64'(4'b0001));
        advance();
        check("t4_we_a", 64'(we_a), 64'(0));
        check("t4_busy", 64'(busy), 64'(0));
        clr_reqs();

`ifdef RF_WB_SCOREBOARD_EN
        // Alloc x9, then write x9: busy through N+1, clear in N+2
        alloc_valid = 1'b1;
        alloc_addr  = 5'd9;
        eval();
        advance();
        alloc_valid = 1'b0;
        check("t5_busy9_set", 64'(busy[9]), 64'(1));
        set_req(0, 1'b1, 5'd9, 32'h99);
        eval();
        advance();
        clr_reqs();
        check("t5_busy9_n1", 64'(busy[9]), 64'(1));
        check("t5_we_a_n1",  64'(we_a),    64'(1));
        eval();
        advance();
        check("t5_busy9_n2", 64'(busy[9]), 64'(0));

        // Re-alloc x9 in N+1 keeps it busy
        alloc_valid = 1'b1;
        alloc_addr  = 5'd9;
        eval();
        advance();
        alloc_valid = 1'b0;
        set_req(2, 1'b1, 5'd9, 32'h98);
        eval();
        advance();
        clr_reqs();
        alloc_valid = 1'b1;
        alloc_addr  = 5'd9;
        eval();
        advance();
        alloc_valid = 1'b0;
        check("t5_busy9_realloc", 64'(busy[9]), 64'(1));

        // Mark x6 pending before the flush
        alloc_valid = 1'b1;
        alloc_addr  = 5'd6;
        eval();
        advance();
        alloc_valid = 1'b0;
        check("t6_busy6", 64'(busy[6]), 64'(1));
`endif

        // Flush with simultaneous alloc x3 and an in-flight write to x10
        set_req(0, 1'b1, 5'd10, 32'hF00D);
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd3;
        eval();
        advance();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        clr_reqs();
        check("t6_busy_flushed", 64'(busy),    64'(0));
        check("t6_we_a",         64'(we_a),    64'(1));
        check("t6_waddr_a",      64'(waddr_a), 64'(10));

        // Randomized traffic
        m_ready = '0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NR; k++) begin
                if (!req_valid[k] || m_ready[k]) begin
                    req_valid[k] = ($urandom_range(0, 9) < 7);
                    req_addr[k]  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
                    req_data[k]  = $urandom;
                end
            end
            alloc_valid = ($urandom_range(0, 2) == 0);
            alloc_addr  = AW'($urandom);
            flush       = ($urandom_range(0, 19) == 0);
            eval();
            advance();
            if (c == 200) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check("mid_rst_we_a", 64'(we_a), 64'(0));
                check("mid_rst_we_b", 64'(we_b), 64'(0));
                check("mid_rst_busy", 64'(busy), 64'(0));
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
